// File: rtl/ball_motion.sv
// ball_motion: per-frame position update for the ball sprite.
// Holds the ball at centre while serving, then moves it every frame tick,
// bouncing off the top/bottom walls and the paddles, and pulses a score
// output when a paddle misses.
// Optional: define BALL_SPEEDUP_EN to add one pixel/frame of speed per
// paddle hit, saturating at MAX_SPEED.

`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef Y_POS_W
`define Y_POS_W 10
`endif

module ball_motion #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int BALL_W         = 10,
    parameter int BALL_H         = 10,
    parameter int PADDLE_W       = 10,
    parameter int PADDLE_H       = 60,
    parameter int LEFT_PADDLE_X  = 20,
    parameter int RIGHT_PADDLE_X = 610,
    parameter int SPEED          = 2,
    parameter int MAX_SPEED      = 6,
    parameter int SERVE_FRAMES   = 60
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick_i,
    input  logic [`Y_POS_W-1:0] left_paddle_y,
    input  logic [`Y_POS_W-1:0] right_paddle_y,
    output logic [`X_POS_W-1:0] ball_x_o,
    output logic [`Y_POS_W-1:0] ball_y_o,
    output logic                serving_o,
    output logic                score_left_o,
    output logic                score_right_o
);
    localparam int XW        = `X_POS_W;
    localparam int YW        = `Y_POS_W;
    localparam int SPD_TOP   = (MAX_SPEED > SPEED) ? MAX_SPEED : SPEED;
    localparam int SPD_W     = $clog2(SPD_TOP + 1);
    localparam int CNT_W     = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [XW-1:0]    CENTRE_X   = XW'((SCREEN_W - BALL_W) / 2);
    localparam logic [YW-1:0]    CENTRE_Y   = YW'((SCREEN_H - BALL_H) / 2);
    localparam logic [YW-1:0]    Y_MAX      = YW'(SCREEN_H - BALL_H);
    localparam logic [XW-1:0]    LEFT_REST  = XW'(LEFT_PADDLE_X + PADDLE_W);
    localparam logic [XW-1:0]    RIGHT_REST = XW'(RIGHT_PADDLE_X - BALL_W);
    localparam logic [SPD_W-1:0] SPEED_INIT = SPD_W'(SPEED);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SERVE_FRAMES - 1);

    // One extra bit on every comparison so sums of position and size never wrap.
    localparam logic [XW:0] LEFT_FACE  = (XW+1)'(LEFT_PADDLE_X + PADDLE_W);
    localparam logic [XW:0] RIGHT_FACE = (XW+1)'(RIGHT_PADDLE_X);
    localparam logic [XW:0] X_LIMIT    = (XW+1)'(SCREEN_W);
    localparam logic [XW:0] BW_X       = (XW+1)'(BALL_W);
    localparam logic [YW:0] Y_LIMIT    = (YW+1)'(SCREEN_H);
    localparam logic [YW:0] BH_Y       = (YW+1)'(BALL_H);
    localparam logic [YW:0] PH_Y       = (YW+1)'(PADDLE_H);

    typedef enum logic [1:0] {SERVE = 2'd0, MOVE = 2'd1, SCORE = 2'd2} state_t;

    state_t           state_reg, state_next;
    logic [XW-1:0]    ball_x_reg, ball_x_next;
    logic [YW-1:0]    ball_y_reg, ball_y_next;
    logic             dir_x_reg, dir_x_next;   // 1 = moving right
    logic             dir_y_reg, dir_y_next;   // 1 = moving down
    logic [SPD_W-1:0] speed_reg, speed_next;
    logic [CNT_W-1:0] serve_cnt_reg, serve_cnt_next;
    logic             score_left_reg, score_left_next;
    logic             score_right_reg, score_right_next;

    logic [XW:0]      x_w, spd_x;
    logic [YW:0]      y_w, spd_y, lpy_w, rpy_w;
    logic             hit_left, hit_right, miss_any;
    logic [SPD_W-1:0] speed_bumped;

    assign x_w   = {1'b0, ball_x_reg};
    assign y_w   = {1'b0, ball_y_reg};
    assign spd_x = (XW+1)'(speed_reg);
    assign spd_y = (YW+1)'(speed_reg);
    assign lpy_w = {1'b0, left_paddle_y};
    assign rpy_w = {1'b0, right_paddle_y};

    // Paddle contact: the ball's leading edge reaches or crosses the paddle face
    // this frame while starting on the playfield side, with vertical overlap.
    assign hit_left  = (x_w <= LEFT_FACE + spd_x) && (x_w >= LEFT_FACE) &&
                       (y_w + BH_Y > lpy_w) && (y_w < lpy_w + PH_Y);
    assign hit_right = (x_w + BW_X + spd_x >= RIGHT_FACE) && (x_w + BW_X <= RIGHT_FACE) &&
                       (y_w + BH_Y > rpy_w) && (y_w < rpy_w + PH_Y);

`ifdef BALL_SPEEDUP_EN
    assign speed_bumped = (speed_reg < SPD_W'(MAX_SPEED)) ? speed_reg + SPD_W'(1) : speed_reg;
`else
    assign speed_bumped = speed_reg;
`endif

    // Next-state and next-position logic; everything waits for a frame tick
    // except the single-cycle SCORE state.
    always_comb begin
        state_next       = state_reg;
        ball_x_next      = ball_x_reg;
        ball_y_next      = ball_y_reg;
        dir_x_next       = dir_x_reg;
        dir_y_next       = dir_y_reg;
        speed_next       = speed_reg;
        serve_cnt_next   = serve_cnt_reg;
        score_left_next  = 1'b0;
        score_right_next = 1'b0;
        miss_any         = 1'b0;
        case (state_reg)
            SERVE: begin
                if (frame_tick_i) begin
                    if (serve_cnt_reg == CNT_LAST) begin
                        serve_cnt_next = '0;
                        state_next     = MOVE;
                    end else begin
                        serve_cnt_next = serve_cnt_reg + CNT_W'(1);
                    end
                end
            end
            MOVE: begin
                if (frame_tick_i) begin
                    if (!dir_y_reg) begin
                        if (y_w <= spd_y) begin
                            ball_y_next = '0;
                            dir_y_next  = 1'b1;
                        end else begin
                            ball_y_next = YW'(y_w - spd_y);
                        end
                    end else begin
                        if (y_w + BH_Y + spd_y >= Y_LIMIT) begin
                            ball_y_next = Y_MAX;
                            dir_y_next  = 1'b0;
                        end else begin
                            ball_y_next = YW'(y_w + spd_y);
                        end
                    end
                    if (!dir_x_reg) begin
                        if (hit_left) begin
                            ball_x_next = LEFT_REST;
                            dir_x_next  = 1'b1;
                            speed_next  = speed_bumped;
                        end else if (x_w <= spd_x) begin
                            miss_any         = 1'b1;
                            score_right_next = 1'b1;
                            dir_x_next       = 1'b0;   // serve toward the left player
                        end else begin
                            ball_x_next = XW'(x_w - spd_x);
                        end
                    end else begin
                        if (hit_right) begin
                            ball_x_next = RIGHT_REST;
                            dir_x_next  = 1'b0;
                            speed_next  = speed_bumped;
                        end else if (x_w + BW_X + spd_x >= X_LIMIT) begin
                            miss_any        = 1'b1;
                            score_left_next = 1'b1;
                            dir_x_next      = 1'b1;    // serve toward the right player
                        end else begin
                            ball_x_next = XW'(x_w + spd_x);
                        end
                    end
                    if (miss_any) begin
                        ball_x_next = CENTRE_X;
                        ball_y_next = CENTRE_Y;
                        speed_next  = SPEED_INIT;
                        state_next  = SCORE;
                    end
                end
            end
            SCORE: begin
                serve_cnt_next = '0;
                state_next     = SERVE;
            end
            default: begin
                state_next = SERVE;
            end
        endcase
    end

    // State and position registers with asynchronous reset to the serve position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= SERVE;
            ball_x_reg      <= CENTRE_X;
            ball_y_reg      <= CENTRE_Y;
            dir_x_reg       <= 1'b1;
            dir_y_reg       <= 1'b1;
            speed_reg       <= SPEED_INIT;
            serve_cnt_reg   <= '0;
            score_left_reg  <= 1'b0;
            score_right_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            ball_x_reg      <= ball_x_next;
            ball_y_reg      <= ball_y_next;
            dir_x_reg       <= dir_x_next;
            dir_y_reg       <= dir_y_next;
            speed_reg       <= speed_next;
            serve_cnt_reg   <= serve_cnt_next;
            score_left_reg  <= score_left_next;
            score_right_reg <= score_right_next;
        end
    end

    assign ball_x_o      = ball_x_reg;
    assign ball_y_o      = ball_y_reg;
    assign serving_o     = (state_reg == SERVE);
    assign score_left_o  = score_left_reg;
    assign score_right_o = score_right_reg;

endmodule
